dcache_uncached_resp: RTL

//  Responder end of the data-side SRAM-like request/response protocol: serves MEM1 requests (req/addr_ok)
//  and returns in-order completions (data_ok/rdata) that MEM2 consumes. Converts each access to a

---
 rtl/dcache_uncached_resp_pkg.sv | 20 ++
 rtl/dcache_uncached_resp_order_fifo.sv | 48 ++++
 rtl/dcache_uncached_resp.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dcache_uncached_resp_pkg.sv
// Shared types and encodings for the uncached data-side responder.
package dcache_uncached_resp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } issue_state_e;

    localparam logic DC_REQ_LOAD  = 1'b0;
    localparam logic DC_REQ_STORE = 1'b1;

    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'd1;

    function automatic logic [2:0] axi_size(input logic [1:0] sz);
        return {1'b0, sz};
    endfunction

endpackage

// File: rtl/dcache_uncached_resp_order_fifo.sv
// Completion-order FIFO: one type bit per accepted request, oldest at head.
module dcache_uncached_resp_order_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic push_type_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= push_type_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push_i && pop_i) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/dcache_uncached_resp.sv
// Uncached data-side responder: SRAM-like req/addr_ok/data_ok to single-beat AXI3.
module dcache_uncached_resp
    import dcache_uncached_resp_pkg::*;
#(
    parameter int         OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID      = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dcache_req,
    input  logic        dcache_wr,
    input  logic [1:0]  dcache_size,
    input  logic [3:0]  dcache_wstrb,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_wdata,
    output logic        dcache_addr_ok,
    output logic        dcache_data_ok,
    output logic [31:0] dcache_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic [3:0]  arlen,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    output logic        wlast,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    issue_state_e state_q, state_d;
    logic [31:0]  addr_q;
    logic [1:0]   size_q;
    logic [3:0]   wstrb_q;
    logic [31:0]  wdata_q;
    logic [31:0]  rdata_q;
    logic         aw_done_q, aw_done_d;
    logic         w_done_q, w_done_d;
    logic         fifo_full, fifo_empty, head_type;
    logic         accept, r_hs, b_hs;

    // Loads and stores never share the FIFO, so channel ordering is trivial.
    assign accept = dcache_req && (state_q == S_IDLE) && !fifo_full
                 && (fifo_empty || (head_type == dcache_wr));

    assign rready = !fifo_empty && (head_type == DC_REQ_LOAD);
    assign bready = !fifo_empty && (head_type == DC_REQ_STORE);
    assign r_hs   = rvalid && rready;
    assign b_hs   = bvalid && bready;

    assign dcache_addr_ok = accept;
    assign dcache_data_ok = r_hs || b_hs;
    assign dcache_rdata   = r_hs ? rdata : rdata_q;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        arvalid   = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = dcache_wr ? S_WR : S_RD;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            S_RD: begin
                arvalid = 1'b1;
                if (arready) state_d = S_IDLE;
            end
            S_WR: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if (awvalid && awready) aw_done_d = 1'b1;
                if (wvalid && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (accept) begin
                addr_q  <= dcache_addr;
                size_q  <= dcache_size;
                wstrb_q <= dcache_wstrb;
                wdata_q <= dcache_wdata;
            end
            if (r_hs) rdata_q <= rdata;
        end
    end

    dcache_uncached_resp_order_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (accept),
        .push_type_i(dcache_wr),
        .pop_i      (dcache_data_ok),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (head_type)
    );

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arsize  = axi_size(size_q);
    assign arlen   = AXI_LEN_SINGLE;
    assign arburst = AXI_BURST_INCR;
    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awsize  = axi_size(size_q);
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

    // A response with no matching head is a slave protocol error.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
        !(rvalid && !rready) && !(bvalid && !bready));

endmodule
